paged_frame_buffer: RTL and testbench

- Single-clock, multi-page block-RAM buffer; successor to the team's two-port paged memory.
- Each page holds one frame of up to RAM_DEPTH words. The writer fills the current page, then commits it with an entry count; the reader consumes committed pages in FIFO order and releases them.
- Page ownership, per-page entry counts and full/empty status are handled internally, so upstream and downstream no longer pass page numbers.
- Sits between the hit-packing stage and the readout serializer.

---
 rtl/pfb_pkg.sv | 30 +++
 rtl/pfb_ram_core.sv | 82 ++++++++
 rtl/paged_frame_buffer.sv | 143 ++++++++++++++
 tb/tb_paged_frame_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfb_pkg.sv
// Shared constants and helpers for the paged frame buffer.
package pfb_pkg;

    localparam string PERF_HIGH = "HIGH_PERFORMANCE";
    localparam string PERF_LOW  = "LOW_LATENCY";

    // Number of bits needed to index 'value' entries.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = value - 1;
        while (v != 0) begin
            v   = v >> 1;
            res = res + 1;
        end
        return res;
    endfunction

    // Word address width within one page.
    function automatic int unsigned addr_width(input int unsigned depth);
        return clogb2(depth);
    endfunction

    // Page index width.
    function automatic int unsigned page_width(input int unsigned pages);
        return clogb2(pages);
    endfunction

endpackage

// File: rtl/pfb_ram_core.sv
// Simple dual-port block RAM with optional output register and valid pipeline.
module pfb_ram_core
    import pfb_pkg::*;
#(
    parameter int unsigned WIDTH       = 18,
    parameter int unsigned ADDR_BITS   = 12,
    parameter string       PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string       INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rvalid
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] ram_q;
    logic             rd_v1_q;

    // Array contents are only set at configuration time; reset never touches them.
    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[ADDR_BITS'(i)] = '0;
        end
    end

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port latch; kept reset-free so it maps onto the RAM primitive.
    always_ff @(posedge clk) begin
        if (re) begin
            ram_q <= mem[raddr];
        end
    end

    // First stage of the read-valid pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v1_q <= 1'b0;
        end else begin
            rd_v1_q <= re;
        end
    end

    if (PERFORMANCE == PERF_LOW) begin : g_low_latency
        assign rdata  = ram_q;
        assign rvalid = rd_v1_q;
    end else begin : g_high_perf
        logic [WIDTH-1:0] dout_q;
        logic             rd_v2_q;

        // Output register stage, loaded only when the RAM latch holds fresh data.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q  <= '0;
                rd_v2_q <= 1'b0;
            end else begin
                rd_v2_q <= rd_v1_q;
                if (rd_v1_q) begin
                    dout_q <= ram_q;
                end
            end
        end

        assign rdata  = dout_q;
        assign rvalid = rd_v2_q;
    end

endmodule

// File: rtl/paged_frame_buffer.sv
// Multi-page frame buffer: writer commits whole pages, reader consumes them in FIFO order.
module paged_frame_buffer
    import pfb_pkg::*;
#(
    parameter int unsigned RAM_WIDTH       = 18,
    parameter int unsigned RAM_DEPTH       = 1024,
    parameter int unsigned PAGES           = 4,
    parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string       INIT_FILE       = "",
    localparam int unsigned AW             = addr_width(RAM_DEPTH),
    localparam int unsigned PW             = page_width(PAGES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [RAM_WIDTH-1:0] wr_data,
    input  logic                 wr_commit,
    input  logic [AW:0]          wr_nent,
    output logic                 wr_full,
    output logic [PW-1:0]        wr_page,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [RAM_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_release,
    output logic                 rd_empty,
    output logic [PW-1:0]        rd_page,
    output logic [AW:0]          rd_nent,
    output logic [PW:0]          pages_used,
    output logic                 err
);

    localparam logic [AW:0] DEPTH_N = (AW + 1)'(RAM_DEPTH);
    localparam logic [PW:0] PAGES_N = (PW + 1)'(PAGES);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [AW:0]   nent_q [PAGES];
    logic          err_q, err_d;

    logic          full, empty;
    logic          wr_ok, commit_ok, rel_ok, rd_ok;
    logic          nent_ovf;
    logic [AW:0]   commit_nent;

    // Accept/reject decisions all use the pre-edge full/empty status.
    always_comb begin
        full        = (count_q == PAGES_N);
        empty       = (count_q == '0);
        wr_ok       = wr_en & ~full;
        commit_ok   = wr_commit & ~full;
        rel_ok      = rd_release & ~empty;
        rd_ok       = rd_en & ~empty;
        nent_ovf    = (wr_nent > DEPTH_N);
        commit_nent = nent_ovf ? DEPTH_N : wr_nent;
    end

    // Next-state for pointers, occupancy and the sticky error flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (commit_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rel_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({commit_ok, rel_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        err_d = err_q
              | (wr_en & full)
              | (wr_commit & full)
              | (commit_ok & nent_ovf)
              | (rd_en & empty)
              | (rd_release & empty);
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Per-page entry counts; commit and release never hit the same page in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PAGES; i++) begin
                nent_q[PW'(i)] <= '0;
            end
        end else begin
            if (rel_ok) begin
                nent_q[rd_ptr_q] <= '0;
            end
            if (commit_ok) begin
                nent_q[wr_ptr_q] <= commit_nent;
            end
        end
    end

    // Status outputs are direct decodes of registered state.
    always_comb begin
        wr_full    = full;
        rd_empty   = empty;
        pages_used = count_q;
        wr_page    = wr_ptr_q;
        rd_page    = rd_ptr_q;
        rd_nent    = empty ? '0 : nent_q[rd_ptr_q];
        err        = err_q;
    end

    pfb_ram_core #(
        .WIDTH       (RAM_WIDTH),
        .ADDR_BITS   (PW + AW),
        .PERFORMANCE (RAM_PERFORMANCE),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_ok),
        .waddr  ({wr_ptr_q, wr_addr}),
        .wdata  (wr_data),
        .re     (rd_ok),
        .raddr  ({rd_ptr_q, rd_addr}),
        .rdata  (rd_data),
        .rvalid (rd_valid)
    );

endmodule

// File: tb/tb_paged_frame_buffer.sv
// Directed bench for paged_frame_buffer with default parameters (HIGH_PERFORMANCE).
module tb_paged_frame_buffer;

    localparam int AW = 10;
    localparam int PW = 2;
    localparam int W  = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, wr_commit, rd_en, rd_release;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [W-1:0]  wr_data, rd_data;
    logic [AW:0]   wr_nent, rd_nent;
    logic          wr_full, rd_empty, rd_valid, err;
    logic [PW-1:0] wr_page, rd_page;
    logic [PW:0]   pages_used;

    int errors = 0;
    int checks = 0;

    paged_frame_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_commit  (wr_commit),
        .wr_nent    (wr_nent),
        .wr_full    (wr_full),
        .wr_page    (wr_page),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_release (rd_release),
        .rd_empty   (rd_empty),
        .rd_page    (rd_page),
        .rd_nent    (rd_nent),
        .pages_used (pages_used),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = W'(d);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic do_commit(input int n);
        wr_commit = 1'b1; wr_nent = (AW + 1)'(n);
        cyc();
        wr_commit = 1'b0;
    endtask

    task automatic do_release();
        rd_release = 1'b1;
        cyc();
        rd_release = 1'b0;
    endtask

    // Issue one read and sample rd_valid one, two and three cycles later.
    task automatic read_word(input int a, output logic [W-1:0] d,
                             output logic v1, output logic v2, output logic v3);
        rd_en = 1'b1; rd_addr = AW'(a);
        cyc();
        rd_en = 1'b0;
        v1 = rd_valid;
        cyc();
        v2 = rd_valid;
        d  = rd_data;
        cyc();
        v3 = rd_valid;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic apply_reset();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_rd_empty: got %b want 1", rd_empty); end
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full: got %b want 0", wr_full); end
        checks++; if (pages_used !== 3'd0) begin errors++; $display("FAIL reset_pages_used: got %0d want 0", pages_used); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (rd_nent !== 11'd0) begin errors++; $display("FAIL reset_rd_nent: got %0d want 0", rd_nent); end
        checks++; if (wr_page !== 2'd0) begin errors++; $display("FAIL reset_wr_page: got %0d want 0", wr_page); end
        checks++; if (rd_page !== 2'd0) begin errors++; $display("FAIL reset_rd_page: got %0d want 0", rd_page); end
        checks++; if (rd_data !== 18'd0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    endtask

    task automatic test_basic_frame();
        logic [W-1:0] d;
        logic v1, v2, v3;
        for (int i = 0; i < 5; i++) do_write(i, 'h100 + i);
        do_commit(5);
        checks++; if (pages_used !== 3'd1) begin errors++; $display("FAIL basic_pages_used: got %0d want 1", pages_used); end
        checks++; if (rd_empty !== 1'b0) begin errors++; $display("FAIL basic_rd_empty: got %b want 0", rd_empty); end
        checks++; if (rd_nent !== 11'd5) begin errors++; $display("FAIL basic_rd_nent: got %0d want 5", rd_nent); end
        checks++; if (rd_page !== 2'd0) begin errors++; $display("FAIL basic_rd_page: got %0d want 0", rd_page); end
        checks++; if (wr_page !== 2'd1) begin errors++; $display("FAIL basic_wr_page: got %0d want 1", wr_page); end
        for (int i = 0; i < 5; i++) begin
            read_word(i, d, v1, v2, v3);
            checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL basic_valid_early[%0d]: got %b want 0", i, v1); end
            checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b want 1", i, v2); end
            checks++; if (d !== W'('h100 + i)) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, d, 'h100 + i); end
            checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL basic_valid_late[%0d]: got %b want 0", i, v3); end
        end
        do_release();
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL basic_release_empty: got %b want 1", rd_empty); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err); end
    endtask

    // Entered with wr_ptr=1, rd_ptr=1, no pages held.
    task automatic test_fill_full();
        logic [W-1:0] d;
        logic v1, v2, v3;
        for (int k = 1; k <= 4; k++) begin
            do_write(0, 'h200 + k);
            do_commit(k);
        end
        checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL full_wr_full: got %b want 1", wr_full); end
        checks++; if (pages_used !== 3'd4) begin errors++; $display("FAIL full_pages_used: got %0d want 4", pages_used); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err_before: got %b want 0", err); end
        do_write(0, 'h3ffff);
        do_commit(7);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL full_err_after: got %b want 1", err); end
        checks++; if (pages_used !== 3'd4) begin errors++; $display("FAIL full_pages_kept: got %0d want 4", pages_used); end
        checks++; if (wr_page !== 2'd1) begin errors++; $display("FAIL full_wr_page: got %0d want 1", wr_page); end
        read_word(0, d, v1, v2, v3);
        checks++; if (d !== 18'h201) begin errors++; $display("FAIL full_dropped_write: got %h want 201", d); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (rd_nent !== 11'(k)) begin errors++; $display("FAIL full_rd_nent[%0d]: got %0d want %0d", k, rd_nent, k); end
            checks++; if (rd_page !== 2'(k % 4)) begin errors++; $display("FAIL full_rd_page[%0d]: got %0d want %0d", k, rd_page, k % 4); end
            do_release();
        end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL full_drained_empty: got %b want 1", rd_empty); end
        checks++; if (pages_used !== 3'd0) begin errors++; $display("FAIL full_drained_used: got %0d want 0", pages_used); end
        apply_reset();
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] d;
        logic v1, v2, v3;
        do_write(0, 'h0aa); do_commit(2);
        do_write(0, 'h0bb); do_commit(3);
        // Commit (with same-cycle write), release and read all in one cycle.
        wr_en = 1'b1; wr_addr = '0; wr_data = 18'h0cc;
        wr_commit = 1'b1; wr_nent = 11'd4;
        rd_release = 1'b1; rd_en = 1'b1; rd_addr = '0;
        cyc();
        wr_en = 1'b0; wr_commit = 1'b0; rd_release = 1'b0; rd_en = 1'b0;
        checks++; if (pages_used !== 3'd2) begin errors++; $display("FAIL simul_pages_used: got %0d want 2", pages_used); end
        checks++; if (wr_page !== 2'd3) begin errors++; $display("FAIL simul_wr_page: got %0d want 3", wr_page); end
        checks++; if (rd_page !== 2'd1) begin errors++; $display("FAIL simul_rd_page: got %0d want 1", rd_page); end
        checks++; if (rd_nent !== 11'd3) begin errors++; $display("FAIL simul_rd_nent: got %0d want 3", rd_nent); end
        cyc();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL simul_rd_valid: got %b want 1", rd_valid); end
        checks++; if (rd_data !== 18'h0aa) begin errors++; $display("FAIL simul_old_page_data: got %h want 0aa", rd_data); end
        do_release();
        checks++; if (rd_nent !== 11'd4) begin errors++; $display("FAIL simul_commit_nent: got %0d want 4", rd_nent); end
        read_word(0, d, v1, v2, v3);
        checks++; if (d !== 18'h0cc) begin errors++; $display("FAIL simul_write_on_commit: got %h want 0cc", d); end
        do_commit(5); do_commit(6); do_commit(7);
        checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL simul_full: got %b want 1", wr_full); end
        // Full: release is taken, commit is rejected.
        wr_commit = 1'b1; wr_nent = 11'd1; rd_release = 1'b1;
        cyc();
        wr_commit = 1'b0; rd_release = 1'b0;
        checks++; if (pages_used !== 3'd3) begin errors++; $display("FAIL simul_full_used: got %0d want 3", pages_used); end
        checks++; if (wr_page !== 2'd2) begin errors++; $display("FAIL simul_full_wr_page: got %0d want 2", wr_page); end
        checks++; if (rd_page !== 2'd3) begin errors++; $display("FAIL simul_full_rd_page: got %0d want 3", rd_page); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL simul_full_err: got %b want 1", err); end
        apply_reset();
        // Empty: commit is taken, release is rejected.
        wr_commit = 1'b1; wr_nent = 11'd9; rd_release = 1'b1;
        cyc();
        wr_commit = 1'b0; rd_release = 1'b0;
        checks++; if (pages_used !== 3'd1) begin errors++; $display("FAIL simul_empty_used: got %0d want 1", pages_used); end
        checks++; if (rd_page !== 2'd0) begin errors++; $display("FAIL simul_empty_rd_page: got %0d want 0", rd_page); end
        checks++; if (wr_page !== 2'd1) begin errors++; $display("FAIL simul_empty_wr_page: got %0d want 1", wr_page); end
        checks++; if (rd_nent !== 11'd9) begin errors++; $display("FAIL simul_empty_nent: got %0d want 9", rd_nent); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL simul_empty_err: got %b want 1", err); end
        apply_reset();
    endtask

    task automatic test_wrap();
        logic [W-1:0] d;
        logic v1, v2, v3;
        int n;
        for (int f = 0; f < 10; f++) begin
            n = f % 4 + 1;
            for (int i = 0; i < n; i++) do_write(i, 'h1000 + f * 16 + i);
            do_commit(n);
            checks++; if (wr_page !== 2'((f + 1) % 4)) begin errors++; $display("FAIL wrap_wr_page[%0d]: got %0d want %0d", f, wr_page, (f + 1) % 4); end
            checks++; if (rd_page !== 2'(f % 4)) begin errors++; $display("FAIL wrap_rd_page[%0d]: got %0d want %0d", f, rd_page, f % 4); end
            checks++; if (rd_nent !== 11'(n)) begin errors++; $display("FAIL wrap_rd_nent[%0d]: got %0d want %0d", f, rd_nent, n); end
            for (int i = 0; i < n; i++) begin
                read_word(i, d, v1, v2, v3);
                checks++; if (v2 !== 1'b1 || d !== W'('h1000 + f * 16 + i)) begin
                    errors++; $display("FAIL wrap_data[%0d][%0d]: got %h valid %b want %h", f, i, d, v2, 'h1000 + f * 16 + i);
                end
            end
            do_release();
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b want 0", err); end
        checks++; if (pages_used !== 3'd0) begin errors++; $display("FAIL wrap_used: got %0d want 0", pages_used); end
        checks++; if (rd_page !== 2'd2) begin errors++; $display("FAIL wrap_final_rd_page: got %0d want 2", rd_page); end
        apply_reset();
    endtask

    task automatic test_boundaries();
        logic [W-1:0] d;
        logic v1, v2, v3;
        do_release();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bnd_rel_empty_err: got %b want 1", err); end
        checks++; if (rd_page !== 2'd0 || wr_page !== 2'd0) begin errors++; $display("FAIL bnd_rel_empty_ptrs: got rd %0d wr %0d want 0 0", rd_page, wr_page); end
        checks++; if (pages_used !== 3'd0) begin errors++; $display("FAIL bnd_rel_empty_used: got %0d want 0", pages_used); end
        apply_reset();
        read_word(0, d, v1, v2, v3);
        checks++; if (v1 !== 1'b0 || v2 !== 1'b0) begin errors++; $display("FAIL bnd_rd_empty_valid: got %b%b want 00", v1, v2); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bnd_rd_empty_err: got %b want 1", err); end
        apply_reset();
        do_commit(0);
        checks++; if (rd_nent !== 11'd0) begin errors++; $display("FAIL bnd_zero_nent: got %0d want 0", rd_nent); end
        checks++; if (rd_empty !== 1'b0) begin errors++; $display("FAIL bnd_zero_empty: got %b want 0", rd_empty); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bnd_zero_err: got %b want 0", err); end
        do_commit(1025);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bnd_ovf_err: got %b want 1", err); end
        checks++; if (pages_used !== 3'd2) begin errors++; $display("FAIL bnd_ovf_used: got %0d want 2", pages_used); end
        do_release();
        checks++; if (rd_nent !== 11'd1024) begin errors++; $display("FAIL bnd_ovf_nent: got %0d want 1024", rd_nent); end
        apply_reset();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        logic v1, v2, v3;
        do_write(0, 'h155); do_commit(1);
        do_write(0, 'h166); do_commit(1);
        rd_en = 1'b1; rd_addr = '0;
        cyc();
        rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid: got %b want 0", rd_valid); end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL mid_rd_empty: got %b want 1", rd_empty); end
        checks++; if (pages_used !== 3'd0) begin errors++; $display("FAIL mid_pages_used: got %0d want 0", pages_used); end
        checks++; if (rd_nent !== 11'd0) begin errors++; $display("FAIL mid_rd_nent: got %0d want 0", rd_nent); end
        rst = 1'b0;
        cyc();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_pipe_flushed: got %b want 0", rd_valid); end
        do_write(0, 'h2a5); do_commit(1);
        checks++; if (rd_page !== 2'd0) begin errors++; $display("FAIL mid_rd_page: got %0d want 0", rd_page); end
        read_word(0, d, v1, v2, v3);
        checks++; if (v2 !== 1'b1 || d !== 18'h2a5) begin errors++; $display("FAIL mid_new_frame: got %h valid %b want 2a5", d, v2); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", err); end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
        wr_addr = '0; wr_data = '0; wr_nent = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_basic_frame();
        test_fill_full();
        test_simultaneous();
        test_wrap();
        test_boundaries();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
